// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side bus of the program counter unit.
//   master : redirect/control sources (stall, pc_src, imm, rs1, halt_req, resume),
//            observes pc, pc_plus4, pc_valid, misaligned, bad_addr
//   slave  : the pc_unit itself
interface pc_unit_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic [1:0]       pc_src;
   logic [31:0]      imm;
   logic [WIDTH-1:0] rs1;
   logic             halt_req;
   logic             resume;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus4;
   logic             pc_valid;
   logic             misaligned;
   logic [WIDTH-1:0] bad_addr;
   modport master (
      output stall, pc_src, imm, rs1, halt_req, resume,
      input  pc, pc_plus4, pc_valid, misaligned, bad_addr
   );
   modport slave (
      input  stall, pc_src, imm, rs1, halt_req, resume,
      output pc, pc_plus4, pc_valid, misaligned, bad_addr
   );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with BOOT/RUN/HALT sequencing, branch/JALR/trap redirect.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pc_unit_if.slave (stall, pc_src, imm, rs1, halt_req, resume in;
//              pc, pc_plus4, pc_valid, misaligned, bad_addr out)
//   Optional macro PC_MISALIGN_TRAP_EN: a misaligned 01/10 target traps instead,
//   pulsing misaligned and capturing the target in bad_addr; otherwise both tie to 0.
module pc_unit #(
   parameter int          WIDTH        = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input logic      clk,
   input logic      rst,
   pc_unit_if.slave bus
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   localparam logic [WIDTH-1:0] RST_PC  = RESET_VECTOR[WIDTH-1:0];
   localparam logic [WIDTH-1:0] TRAP_PC = TRAP_VECTOR[WIDTH-1:0];
   state_t           state, state_n;
   logic [WIDTH-1:0] pc_q, pc_n;
   logic [WIDTH-1:0] imm_w, br_tgt, jr_sum, target;
   logic             trap;
   // truncating to WIDTH bits keeps two's-complement wrap for narrow PCs
   assign imm_w  = bus.imm[WIDTH-1:0];
   assign br_tgt = pc_q + imm_w;
   assign jr_sum = bus.rs1 + imm_w;
   assign target = bus.pc_src == 2'b01 ? br_tgt : {jr_sum[WIDTH-1:1], 1'b0};
   assign trap   = bus.pc_src == 2'b11 && state != BOOT;
   assign bus.pc       = pc_q;
   assign bus.pc_plus4 = pc_q + WIDTH'(4);
   assign bus.pc_valid = state == RUN;
`ifdef PC_MISALIGN_TRAP_EN
   logic             mis_q, mis_n;
   logic [WIDTH-1:0] bad_q, bad_n;
   assign bus.misaligned = mis_q;
   assign bus.bad_addr   = bad_q;
`else
   assign bus.misaligned = 1'b0;
   assign bus.bad_addr   = '0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT;
         pc_q  <= RST_PC;
`ifdef PC_MISALIGN_TRAP_EN
         mis_q <= 1'b0;
         bad_q <= '0;
`endif
      end else begin
         state <= state_n;
         pc_q  <= pc_n;
`ifdef PC_MISALIGN_TRAP_EN
         mis_q <= mis_n;
         bad_q <= bad_n;
`endif
      end
   end
   // priority: trap, halt_req, stall, then the normal next-PC select
   always_comb begin
      state_n = state;
      pc_n    = pc_q;
`ifdef PC_MISALIGN_TRAP_EN
      mis_n   = 1'b0;
      bad_n   = bad_q;
`endif
      if (state == BOOT) begin
         state_n = RUN;
      end else if (trap) begin
         state_n = RUN;
         pc_n    = TRAP_PC;
      end else if (state == HALT) begin
         state_n = bus.halt_req || !bus.resume ? HALT : RUN;
      end else if (bus.halt_req) begin
         state_n = HALT;
      end else if (!bus.stall) begin
         pc_n = bus.pc_src == 2'b00 ? bus.pc_plus4 : target;
`ifdef PC_MISALIGN_TRAP_EN
         if (bus.pc_src != 2'b00 && target[1:0] != 2'b00) begin
            pc_n  = TRAP_PC;
            mis_n = 1'b1;
            bad_n = target;
         end
`endif
      end
   end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (WIDTH=32 and WIDTH=8 instances).
module tb_pc_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   pc_unit_if #(.WIDTH(32)) b32 ();
   pc_unit_if #(.WIDTH(8))  b8 ();
   pc_unit #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
   pc_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set32(input logic st, input logic [1:0] src, input logic [31:0] im,
                        input logic [31:0] r1, input logic hr, input logic rs);
      b32.stall = st; b32.pc_src = src; b32.imm = im;
      b32.rs1 = r1; b32.halt_req = hr; b32.resume = rs;
   endtask
   task automatic set8(input logic [1:0] src, input logic [31:0] im, input logic [7:0] r1);
      b8.stall = 1'b0; b8.pc_src = src; b8.imm = im;
      b8.rs1 = r1; b8.halt_req = 1'b0; b8.resume = 1'b0;
   endtask
   initial begin
      set32(0, 2'b00, 0, 0, 0, 0);
      set8(2'b00, 0, 8'h00);
      step();
      chk("rst_pc", b32.pc, 32'h0);
      chk("rst_valid", b32.pc_valid, 0);
      chk("rst_mis", b32.misaligned, 0);
      chk("rst_bad", b32.bad_addr, 0);
      rst = 1'b0;
      step(); chk("boot_pc", b32.pc, 32'h0); chk("boot_valid", b32.pc_valid, 1);
      step(); chk("seq_4", b32.pc, 32'h4);
      step(); chk("seq_8", b32.pc, 32'h8);
      step(); chk("seq_c", b32.pc, 32'hC);
      chk("plus4_c", b32.pc_plus4, 32'h10);
      set32(0, 2'b10, 0, 32'h40, 0, 0); step(); chk("jalr_40", b32.pc, 32'h40);
      set32(0, 2'b01, -32'sd8, 0, 0, 0); step(); chk("br_neg8", b32.pc, 32'h38);
      set32(0, 2'b10, 32'h10, 32'h1001, 0, 0); step(); chk("jalr_clr0", b32.pc, 32'h1010);
      set32(0, 2'b10, 0, 32'h20, 0, 0); step(); chk("jalr_20", b32.pc, 32'h20);
      set32(1, 2'b01, 32'h100, 0, 0, 0); step(); chk("stall_1", b32.pc, 32'h20);
      step(); chk("stall_2", b32.pc, 32'h20); chk("stall_valid", b32.pc_valid, 1);
      set32(0, 2'b00, 0, 0, 0, 0); step(); chk("unstall", b32.pc, 32'h24);
      set32(0, 2'b10, 0, 32'h8, 0, 0); step(); chk("jalr_8", b32.pc, 32'h8);
      set32(0, 2'b01, 32'h40, 0, 1, 0); step();
      chk("halt_pc", b32.pc, 32'h8); chk("halt_valid", b32.pc_valid, 0);
      set32(0, 2'b00, 0, 0, 0, 0); step(); chk("halt_hold", b32.pc, 32'h8);
      set32(0, 2'b00, 0, 0, 1, 1); step(); chk("halt_both", b32.pc_valid, 0);
      set32(0, 2'b00, 0, 0, 0, 1); step();
      chk("resume_valid", b32.pc_valid, 1); chk("resume_pc", b32.pc, 32'h8);
      set32(0, 2'b00, 0, 0, 0, 0); step(); chk("resume_next", b32.pc, 32'hC);
      set32(0, 2'b00, 0, 0, 1, 0); step(); chk("halt2_valid", b32.pc_valid, 0);
      set32(0, 2'b11, 0, 0, 0, 0); step();
      chk("trap_halt_pc", b32.pc, 32'h100); chk("trap_halt_valid", b32.pc_valid, 1);
      set32(0, 2'b00, 0, 0, 0, 0); step(); chk("post_trap", b32.pc, 32'h104);
      set32(1, 2'b11, 0, 0, 1, 0); step(); chk("trap_over_stall", b32.pc, 32'h100);
      chk("trap_over_halt", b32.pc_valid, 1);
      set32(0, 2'b10, 0, 32'h10, 0, 0); step(); chk("jalr_10", b32.pc, 32'h10);
      set32(1, 2'b01, 32'h6, 0, 0, 0); step();
      chk("stall_mis_pc", b32.pc, 32'h10); chk("stall_mis_flag", b32.misaligned, 0);
      set32(0, 2'b01, 32'h6, 0, 0, 0); step();
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_pc", b32.pc, 32'h100);
      chk("mis_flag", b32.misaligned, 1);
      chk("mis_bad", b32.bad_addr, 32'h16);
      set32(0, 2'b00, 0, 0, 0, 0); step();
      chk("mis_pulse_end", b32.misaligned, 0);
      chk("mis_bad_keep", b32.bad_addr, 32'h16);
      chk("mis_next_pc", b32.pc, 32'h104);
`else
      chk("mis_pc", b32.pc, 32'h16);
      chk("mis_flag", b32.misaligned, 0);
      chk("mis_bad", b32.bad_addr, 0);
      set32(0, 2'b00, 0, 0, 0, 0); step();
      chk("mis_next_pc", b32.pc, 32'h1A);
`endif
      set32(0, 2'b00, 0, 0, 1, 0); step(); chk("halt3_valid", b32.pc_valid, 0);
      rst = 1'b1;
      set32(1, 2'b11, 0, 0, 1, 1); step();
      chk("rst_halt_pc", b32.pc, 32'h0); chk("rst_halt_valid", b32.pc_valid, 0);
      chk("rst_halt_mis", b32.misaligned, 0); chk("rst_halt_bad", b32.bad_addr, 0);
      rst = 1'b0;
      set32(0, 2'b00, 0, 0, 0, 0); step();
      chk("rerun_pc", b32.pc, 32'h0); chk("rerun_valid", b32.pc_valid, 1);
      set8(2'b10, 0, 8'hFC); step(); chk("w8_jalr_fc", b8.pc, 32'hFC);
      chk("w8_plus4", b8.pc_plus4, 32'h00);
      set8(2'b00, 0, 8'h00); step(); chk("w8_wrap", b8.pc, 32'h00);
      set8(2'b01, 32'h7FFF_FF04, 8'h00); step(); chk("w8_trunc", b8.pc, 32'h04);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC/address width in bits; legal range 8..32.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset; low 2 bits zero.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, PC value loaded on trap; low 2 bits zero.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  hold PC this cycle (e.g. fetch or hazard back-pressure).
REQ-007 pc_src  input  2  next-PC select: 00 sequential, 01 PC-relative branch/JAL, 10 register-relative JALR, 11 trap.
REQ-008 imm  input  32  signed immediate offset, byte units.
REQ-009 rs1  input  WIDTH  base register value for JALR.
REQ-010 halt_req  input  1  request to enter HALT.
REQ-011 resume  input  1  request to leave HALT.
REQ-012 pc  output  WIDTH  current fetch address (registered).
REQ-013 pc_plus4  output  WIDTH  pc+4, combinational, modulo 2^WIDTH.
REQ-014 pc_valid  output  1  pc holds a fetchable address this cycle.
REQ-015 misaligned  output  1  one-cycle pulse on misaligned redirect (macro-dependent).
REQ-016 bad_addr  output  WIDTH  last misaligned target (macro-dependent).

Function
REQ-017 FSM states BOOT, RUN, HALT; pc_valid SHALL be 1 only in RUN.
REQ-018 BOOT SHALL last exactly one cycle after rst deasserts, then go to RUN; pc holds RESET_VECTOR.
REQ-019 imm SHALL be truncated to its low WIDTH bits (sign preserved for WIDTH<32); all adds wrap modulo 2^WIDTH.
REQ-020 In RUN with no higher-priority event: 00 -> pc+4; 01 -> pc+imm; 10 -> (rs1+imm) with bit 0 cleared.
REQ-021 pc_src=11 in RUN or HALT SHALL load TRAP_VECTOR next cycle and set state RUN, overriding stall, halt_req and resume.
REQ-022 Priority, highest first: rst, trap, halt_req, stall, pc_src 00/01/10.
REQ-023 halt_req in RUN (no trap) SHALL hold pc and enter HALT next cycle; the redirect in that cycle is discarded.
REQ-024 In HALT pc SHALL hold; resume=1 SHALL return to RUN next cycle with pc unchanged; halt_req and resume both high in HALT -> stay HALT.
REQ-025 stall=1 in RUN SHALL hold pc and discard that cycle's redirect; the source must re-present it.
REQ-026 pc SHALL update on every non-stalled RUN cycle (single-cycle latency, no bubbles).
REQ-027 pc+4 wrap from 2^WIDTH-4 SHALL yield 0 with no flag.

Reset
REQ-028 On rst: pc=RESET_VECTOR, state=BOOT, pc_valid=0, misaligned=0, bad_addr=0.
REQ-029 rst mid-HALT, mid-stall or coincident with trap SHALL win; all pending requests are dropped.

Configuration
REQ-030 Macro PC_MISALIGN_TRAP_EN: when defined, a 01/10 redirect whose target has bits[1:0]!=0 SHALL load TRAP_VECTOR instead, pulse misaligned for one cycle and capture the target in bad_addr.
REQ-031 Without PC_MISALIGN_TRAP_EN: the target is loaded unchanged, misaligned is tied 0 and bad_addr is tied 0.
REQ-032 A stalled or halted misaligned redirect SHALL NOT raise misaligned.

Verification
REQ-033 rst 1 cycle, then idle 00 for 4 cycles -> pc 0 (pc_valid 0), 0, 4, 8, 0xC.
REQ-034 pc=0x40, pc_src=01, imm=-8 -> pc=0x38; then pc_src=10, rs1=0x1001, imm=0x10 -> pc=0x1010.
REQ-035 pc=0x20, stall=1 with pc_src=01, imm=0x100 for 2 cycles -> pc stays 0x20; stall=0 with 00 -> 0x24.
REQ-036 halt_req in RUN at pc=0x8 -> HALT, pc_valid 0, pc 0x8; resume -> RUN, pc 0x8 then 0xC; trap while halted -> pc 0x100, RUN.
REQ-037 WIDTH=8, pc=0xFC, 00 -> pc=0x00; pc_src=01, imm=0x7FFF_FF04 -> pc=0x04.
REQ-038 With PC_MISALIGN_TRAP_EN, pc=0x10, pc_src=01, imm=6 -> pc=0x100, misaligned 1 for one cycle, bad_addr=0x16; without the macro -> pc=0x16, misaligned 0.
